// File: rtl/ras_pkg.sv
// Shared types and helpers for the return-address-stack controller.
package ras_pkg;

    typedef enum logic [1:0] {
        RAS_NONE = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_REPL = 2'd3
    } ras_op_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ras_ctrl_stack.sv
// Shift-register LIFO without reset: head at index 0, write/move controls applied together.
module stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_me,
    input  logic             i_md,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // md=0 shifts toward the bottom (push), md=1 toward the head (pop); a head write wins over the shift
    always_ff @(posedge clk) begin
        if (i_me && !i_md) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_mem[i] <= r_mem[i-1];
            end
        end else if (i_me && i_md) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_mem[i] <= r_mem[i+1];
            end
        end
        if (i_we) begin
            r_mem[0] <= i_data;
        end
    end

    assign o_data = r_mem[0];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: decodes call/return hints, drives the stack and
// tracks occupancy with a one-level checkpoint for misprediction recovery.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10,
    parameter int INC   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_call,
    input  logic                      i_ret,
    input  logic [WIDTH-1:0]          i_pc,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_ckpt,
    input  logic                      i_restore,
    output logic                      o_pred_valid,
    output logic [WIDTH-1:0]          o_pred_addr,
    output logic [cnt_w(DEPTH)-1:0]   o_count,
    output logic                      o_ovf,
    output logic                      o_udf
);

    localparam int            CW   = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_ckpt;
    logic             r_ovf;
    logic             r_udf;

    ras_op_t          w_op;
    logic             w_we;
    logic             w_me;
    logic             w_md;
    logic [WIDTH-1:0] w_link;
    logic [WIDTH-1:0] w_top;
    logic [CW-1:0]    w_count_nxt;

    assign w_link = i_pc + WIDTH'(INC);

    always_comb begin
        w_op = RAS_NONE;
        if (!rst && !i_stall && !i_flush && !i_restore) begin
            unique case ({i_call, i_ret})
                2'b10:   w_op = RAS_PUSH;
                2'b01:   w_op = RAS_POP;
                2'b11:   w_op = RAS_REPL;
                default: w_op = RAS_NONE;
            endcase
        end
    end

    // A pop on an empty stack leaves the LIFO alone so live entries are never shifted out of view
    always_comb begin
        w_we        = 1'b0;
        w_me        = 1'b0;
        w_md        = 1'b0;
        w_count_nxt = r_count;
        unique case (w_op)
            RAS_PUSH: begin
                w_we = 1'b1;
                w_me = 1'b1;
                if (r_count != FULL) begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
            RAS_POP: begin
                if (r_count != '0) begin
                    w_me        = 1'b1;
                    w_md        = 1'b1;
                    w_count_nxt = r_count - CW'(1);
                end
            end
            RAS_REPL: begin
                w_we = 1'b1;
                if (r_count == '0) begin
                    w_count_nxt = CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_ckpt  <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (i_restore) begin
            r_count <= r_ckpt;
        end else begin
            r_count <= w_count_nxt;
            if (!i_stall && i_ckpt) begin
                r_ckpt <= w_count_nxt;
            end
            if (w_op == RAS_PUSH && r_count == FULL) begin
                r_ovf <= 1'b1;
            end
            if (w_op == RAS_POP && r_count == '0) begin
                r_udf <= 1'b1;
            end
        end
    end

    stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk    (clk),
        .i_we   (w_we),
        .i_me   (w_me),
        .i_md   (w_md),
        .i_data (w_link),
        .o_data (w_top)
    );

    assign o_pred_addr  = w_top;
    assign o_pred_valid = (r_count != '0);
    assign o_count      = r_count;
    assign o_ovf        = r_ovf;
    assign o_udf        = r_udf;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed vector table followed by random traffic against a queue-based model.
module tb_ras_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int INC   = 4;

    localparam bit [6:0] NOP = 7'b0000000;
    localparam bit [6:0] RST = 7'b1000000;
    localparam bit [6:0] CAL = 7'b0100000;
    localparam bit [6:0] RET = 7'b0010000;
    localparam bit [6:0] STL = 7'b0001000;
    localparam bit [6:0] FLS = 7'b0000100;
    localparam bit [6:0] CKP = 7'b0000010;
    localparam bit [6:0] RSR = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst, i_call, i_ret, i_stall, i_flush, i_ckpt, i_restore;
    logic [WIDTH-1:0] i_pc;
    logic             o_pred_valid, o_ovf, o_udf;
    logic [WIDTH-1:0] o_pred_addr;
    logic [2:0]       o_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ras_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INC(INC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_call       (i_call),
        .i_ret        (i_ret),
        .i_pc         (i_pc),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_ckpt       (i_ckpt),
        .i_restore    (i_restore),
        .o_pred_valid (o_pred_valid),
        .o_pred_addr  (o_pred_addr),
        .o_count      (o_count),
        .o_ovf        (o_ovf),
        .o_udf        (o_udf)
    );

    typedef struct {
        bit [6:0]    ctl;
        logic [15:0] pc;
        int          cnt;
        bit          v;
        logic [15:0] addr;
        bit          ovf;
        bit          udf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit [6:0] ctl, logic [15:0] pc, int cnt, bit v,
                                logic [15:0] addr, bit ovf, bit udf);
        vec_t t;
        t.ctl = ctl; t.pc = pc; t.cnt = cnt; t.v = v;
        t.addr = addr; t.ovf = ovf; t.udf = udf;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit [6:0] ctl, input logic [15:0] pc);
        {rst, i_call, i_ret, i_stall, i_flush, i_ckpt, i_restore} = ctl;
        i_pc = pc;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: known stack entries (head first) plus counters
    logic [15:0] mq[$];
    int          m_cnt, m_ckpt;
    bit          m_ovf, m_udf;

    task automatic model_step(input bit [6:0] ctl, input logic [15:0] pc);
        bit r, c, t, s, f, k, q;
        logic [15:0] link;
        {r, c, t, s, f, k, q} = ctl;
        link = pc + 16'(INC);
        if (r) begin
            m_cnt = 0; m_ckpt = 0; m_ovf = 0; m_udf = 0;
        end else if (f) begin
            m_cnt = 0;
        end else if (q) begin
            m_cnt = m_ckpt;
        end else if (!s) begin
            if (c && t) begin
                if (mq.size() == 0) mq.push_front(link);
                else mq[0] = link;
                if (m_cnt == 0) m_cnt = 1;
            end else if (c) begin
                if (m_cnt == DEPTH) m_ovf = 1;
                mq.push_front(link);
                if (mq.size() > DEPTH) void'(mq.pop_back());
                if (m_cnt < DEPTH) m_cnt++;
            end else if (t) begin
                if (m_cnt == 0) m_udf = 1;
                else begin
                    m_cnt--;
                    if (mq.size() > 0) void'(mq.pop_front());
                end
            end
            if (k) m_ckpt = m_cnt;
        end
    endtask

    initial begin
        {rst, i_call, i_ret, i_stall, i_flush, i_ckpt, i_restore} = '0;
        i_pc = '0;

        tbl.push_back(mk(RST,       16'h0000, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(CAL,       16'h0100, 1, 1, 16'h0104, 0, 0));
        tbl.push_back(mk(CAL,       16'h0200, 2, 1, 16'h0204, 0, 0));
        tbl.push_back(mk(CAL,       16'h0300, 3, 1, 16'h0304, 0, 0));
        tbl.push_back(mk(RET,       16'h0000, 2, 1, 16'h0204, 0, 0));
        tbl.push_back(mk(RET,       16'h0000, 1, 1, 16'h0104, 0, 0));
        tbl.push_back(mk(RET,       16'h0000, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(CAL,       16'h0010, 1, 1, 16'h0014, 0, 0));
        tbl.push_back(mk(CAL,       16'h0020, 2, 1, 16'h0024, 0, 0));
        tbl.push_back(mk(CAL,       16'h0030, 3, 1, 16'h0034, 0, 0));
        tbl.push_back(mk(CAL,       16'h0040, 4, 1, 16'h0044, 0, 0));
        tbl.push_back(mk(CAL,       16'h0050, 4, 1, 16'h0054, 1, 0));
        tbl.push_back(mk(RET,       16'h0000, 3, 1, 16'h0044, 1, 0));
        tbl.push_back(mk(RET,       16'h0000, 2, 1, 16'h0034, 1, 0));
        tbl.push_back(mk(RET,       16'h0000, 1, 1, 16'h0024, 1, 0));
        tbl.push_back(mk(RET,       16'h0000, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(RET,       16'h0000, 0, 0, 16'h0000, 1, 1));
        tbl.push_back(mk(RST,       16'h0000, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(CAL,       16'h0000, 1, 1, 16'h0004, 0, 0));
        tbl.push_back(mk(CAL,       16'h0100, 2, 1, 16'h0104, 0, 0));
        tbl.push_back(mk(CAL|RET,   16'h0800, 2, 1, 16'h0804, 0, 0));
        tbl.push_back(mk(RET,       16'h0000, 1, 1, 16'h0004, 0, 0));
        tbl.push_back(mk(CAL,       16'h0100, 2, 1, 16'h0104, 0, 0));
        tbl.push_back(mk(CKP,       16'h0000, 2, 1, 16'h0104, 0, 0));
        tbl.push_back(mk(CAL,       16'h0200, 3, 1, 16'h0204, 0, 0));
        tbl.push_back(mk(CAL,       16'h0300, 4, 1, 16'h0304, 0, 0));
        tbl.push_back(mk(RSR|CAL,   16'h0900, 2, 1, 16'h0304, 0, 0));
        tbl.push_back(mk(CAL,       16'h0400, 3, 1, 16'h0404, 0, 0));
        tbl.push_back(mk(FLS|CAL,   16'h0500, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(STL|RET,   16'h0000, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(CAL,       16'hFFFE, 1, 1, 16'h0002, 0, 0));
        tbl.push_back(mk(CAL,       16'h0010, 2, 1, 16'h0014, 0, 0));
        tbl.push_back(mk(CAL,       16'h0020, 3, 1, 16'h0024, 0, 0));
        tbl.push_back(mk(RST|CAL,   16'h0030, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(CAL,       16'h1000, 1, 1, 16'h1004, 0, 0));
        tbl.push_back(mk(STL|CAL,   16'h2000, 1, 1, 16'h1004, 0, 0));
        tbl.push_back(mk(STL|CKP,   16'h0000, 1, 1, 16'h1004, 0, 0));
        tbl.push_back(mk(RSR,       16'h0000, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(CAL,       16'h3000, 1, 1, 16'h3004, 0, 0));
        tbl.push_back(mk(CKP|RSR,   16'h0000, 0, 0, 16'h0000, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].ctl, tbl[i].pc);
            chk("count", i, 32'(o_count), 32'(tbl[i].cnt));
            chk("valid", i, 32'(o_pred_valid), 32'(tbl[i].v));
            chk("ovf",   i, 32'(o_ovf), 32'(tbl[i].ovf));
            chk("udf",   i, 32'(o_udf), 32'(tbl[i].udf));
            if (tbl[i].v) chk("addr", i, 32'(o_pred_addr), 32'(tbl[i].addr));
        end

        // Random traffic against the model, starting from a known reset
        mq.delete();
        model_step(RST, 16'h0);
        drive(RST, 16'h0);
        for (int n = 0; n < 600; n++) begin
            bit [6:0]    ctl;
            logic [15:0] pc;
            int          sel;
            ctl = NOP;
            sel = $urandom_range(0, 99);
            if (sel < 40)      ctl = CAL;
            else if (sel < 75) ctl = RET;
            else if (sel < 83) ctl = CAL | RET;
            if ($urandom_range(0, 99) < 10) ctl |= STL;
            if ($urandom_range(0, 99) < 3)  ctl |= FLS;
            if ($urandom_range(0, 99) < 10) ctl |= CKP;
            if ($urandom_range(0, 99) < 5)  ctl |= RSR;
            if ($urandom_range(0, 199) < 2) ctl |= RST;
            pc = 16'($urandom);
            if ($urandom_range(0, 19) == 0) pc = 16'hFFFC | 16'($urandom_range(0, 3));
            model_step(ctl, pc);
            drive(ctl, pc);
            chk("rnd_count", n, 32'(o_count), 32'(m_cnt));
            chk("rnd_valid", n, 32'(o_pred_valid), 32'(m_cnt != 0));
            chk("rnd_ovf",   n, 32'(o_ovf), 32'(m_ovf));
            chk("rnd_udf",   n, 32'(o_udf), 32'(m_udf));
            if (mq.size() > 0) chk("rnd_addr", n, 32'(o_pred_addr), 32'(mq[0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack controller for the fetch-stage branch predictor.
- Decodes per-cycle call/return hints, computes the link address and drives the team's `stack` LIFO, which it instantiates internally.
- Tracks occupancy, since `stack` has no reset and no count. Reports a validated return-target prediction, overflow/underflow flags and a single-level occupancy checkpoint for misprediction recovery.

Parameters:
- WIDTH, 16, address width in bits; passed through to `stack`.
- DEPTH, 10, stack entries; passed through to `stack`.
- INC, 4, byte offset added to i_pc to form the link address.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_call  in  1  fetched instruction is a call; push link address
- i_ret  in  1  fetched instruction is a return; pop
- i_pc  in  WIDTH  PC of the hinted instruction
- i_stall  in  1  fetch stalled; ignore call/ret/ckpt this cycle
- i_flush  in  1  pipeline flush; empty the stack
- i_ckpt  in  1  save current occupancy into the checkpoint register
- i_restore  in  1  reload occupancy from the checkpoint register
- o_pred_valid  out  1  o_pred_addr holds a live entry
- o_pred_addr  out  WIDTH  predicted return target (top of stack)
- o_count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- o_ovf  out  1  sticky: a push occurred while count==DEPTH
- o_udf  out  1  sticky: a pop occurred while count==0

Behaviour:
- Reset (rst=1 at posedge): count=0, ckpt=0, o_ovf=0, o_udf=0; o_pred_valid=0 from the next cycle. Stack contents are left untouched, since `stack` has no reset; count gates validity.
- Link address: i_pc + INC, truncated to WIDTH bits; wraps modulo 2^WIDTH.
- Effective op (only when i_stall=0, rst=0, i_flush=0, i_restore=0):
  - PUSH (call only): stack we=1, me=1, md=0, in=link.
  - POP (ret only): we=0, me=1, md=1.
  - REPL (call and ret): we=1, me=0, in=link; head overwritten, tail untouched.
  - NONE: we=0, me=0.
- Stack control signals are combinational from the inputs; the stack updates at the same edge.
- Count update:
  - PUSH: count+1, saturating at DEPTH. At count==DEPTH the push still occurs, the bottom entry is lost, and o_ovf is set.
  - POP at count>0: count-1.
  - POP at count==0: stack not moved (me=0), count stays 0, o_udf set.
  - REPL: count unchanged, except count==0 becomes 1.
- Priority, highest first: rst > i_flush > i_restore > op.
  - i_flush: count<=0; all stack controls 0; ckpt unchanged; flags unchanged.
  - i_restore: count<=ckpt; any same-cycle call/ret dropped; stack contents not rewound (accepted predictor approximation).
- i_ckpt (when i_stall=0, no flush/rst): ckpt<=count after the same-cycle op is applied. With i_restore in the same cycle, ckpt<=ckpt (restore value).
- Output timing:
  - o_pred_addr = stack out, combinational from the stack head register.
  - o_pred_valid = (count!=0), registered via count.
  - Latency: a push at edge N is visible on o_pred_addr/o_pred_valid after edge N; a pop at edge N exposes the next entry after edge N.
- o_ovf/o_udf are cleared only by rst.
- i_stall=1 with call/ret: no stack or count change.

Decomposition:
- Package ras_pkg:
  - enum ras_op_t {RAS_NONE, RAS_PUSH, RAS_POP, RAS_REPL};
  - function cnt_w(depth) = $clog2(depth+1).
- Sub-modules:
  - one instance of `stack` (WIDTH, DEPTH);
  - op decode plus counter logic in ras_ctrl itself (no further split).

Test Plan (WIDTH=16, DEPTH=4, INC=4):
- rst, then 3 calls with pc=0x0100, 0x0200, 0x0300 -> o_count=3, o_pred_addr=0x0304; 3 rets -> addr 0x0204, then 0x0104, then o_pred_valid=0, o_count=0, o_udf=0.
- 5 calls with pc=0x10,0x20,0x30,0x40,0x50 -> o_count=4, o_ovf=1; 4 rets yield 0x54, 0x44, 0x34, 0x24; 5th ret -> o_udf=1, o_count=0.
- count=2 (top 0x0104), call+ret same cycle with pc=0x0800 -> o_pred_addr=0x0804, o_count=2; ret -> next entry unchanged.
- count=2, i_ckpt; 2 calls -> count=4; i_restore with i_call=1 -> o_count=2, call dropped.
- count=3, i_flush with i_call=1 -> o_count=0, o_pred_valid=0; i_stall=1 with i_ret -> no change; pc=0xFFFE call -> o_pred_addr=0x0002.
- Reset mid-sequence with count=3 and i_call=1 -> o_count=0, flags 0, o_pred_valid=0 next cycle.
